// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared pipeline definitions: ALU opcodes, write-back select,
//                multiply/divide iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_NOR   = 5'd5,
        ALU_SLT   = 5'd6,
        ALU_SLTU  = 5'd7,
        ALU_SLL   = 5'd8,
        ALU_SRL   = 5'd9,
        ALU_SRA   = 5'd10,
        ALU_MFHI  = 5'd11,
        ALU_MFLO  = 5'd12,
        ALU_MULT  = 5'd13,
        ALU_MULTU = 5'd14,
        ALU_DIV   = 5'd15,
        ALU_DIVU  = 5'd16
    } alu_op_e;

    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC4 = 2'b10;

    localparam int MD_ITER_DEFAULT = 32;

    function automatic logic is_md_op(input alu_op_e op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

    // Every opcode that reads or writes HI/LO must wait for the unit.
    function automatic logic is_hilo_op(input alu_op_e op);
        return is_md_op(op) || (op == ALU_MFHI) || (op == ALU_MFLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Iterative shift-add multiplier / restoring divider with
//                HI/LO result registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import cpu_pkg::*;
#(
    parameter int MD_ITER = MD_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        start,
    input  logic        is_div,
    input  logic        is_signed,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int             CW         = $clog2(MD_ITER);
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(MD_ITER - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ITER = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_acc;
    logic [31:0]   r_opd;
    logic          r_div;
    logic          r_neg_lo;
    logic          r_neg_hi;
    logic          r_div0;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_msum;
    logic [32:0] w_rsh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;

    assign w_a_mag = (is_signed && opa[31]) ? (32'd0 - opa) : opa;
    assign w_b_mag = (is_signed && opb[31]) ? (32'd0 - opb) : opb;

    // Multiply: r_acc = {partial, multiplier}; divide: r_acc = {remainder, dividend/quotient}.
    assign w_msum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
    assign w_rsh  = r_acc[63:31];
    assign w_ge   = (w_rsh >= {1'b0, r_opd});
    assign w_sub  = w_rsh[31:0] - r_opd;

    assign w_acc_next = r_div ? (w_ge ? {w_sub, r_acc[30:0], 1'b1}
                                      : {w_rsh[31:0], r_acc[30:0], 1'b0})
                              : {w_msum, r_acc[31:1]};

    assign w_prod = r_neg_lo ? (64'd0 - r_acc) : r_acc;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state  <= c_ST_ITER;
                        r_cnt    <= '0;
                        r_div    <= is_div;
                        r_neg_lo <= is_signed & (opa[31] ^ opb[31]);
                        r_neg_hi <= is_signed & opa[31];
                        r_div0   <= is_div & (opb == 32'd0);
                        r_opd    <= is_div ? w_b_mag : w_a_mag;
                        r_acc    <= {32'd0, is_div ? w_a_mag : w_b_mag};
                    end
                end
                c_ST_ITER: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    if (r_div) begin
                        // Divide by zero keeps the all-ones quotient unsigned.
                        r_lo <= r_div0   ? 32'hFFFF_FFFF
                              : r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
                        r_hi <= r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == c_ST_ITER) || (r_state == c_ST_FIX);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage: single-cycle ALU, HI/LO hazard stall and the
//                EX/MEM pipeline register, plus the multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import cpu_pkg::*;
#(
    parameter int MD_ITER = MD_ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        id_valid,
    input  logic [4:0]  alu_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [4:0]  shamt,
    input  logic [31:0] store_data,
    input  logic [4:0]  write_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        lu_op,
    input  logic [1:0]  mem_to_reg,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] lu_data,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] ex_alu_s,
    output logic [31:0] ex_mem_wdata,
    output logic [31:0] ex_pc_plus4,
    output logic [31:0] ex_lu_data,
    output logic [4:0]  ex_write_reg,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_lu_op,
    output logic [1:0]  ex_mem_to_reg,
    output logic        md_busy
);

    alu_op_e     w_op;
    logic [31:0] w_alu;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_md_start;
    logic        w_bubble;

    assign w_op       = alu_op_e'(alu_op);
    assign stall      = id_valid & md_busy & is_hilo_op(w_op);
    assign w_md_start = id_valid & ~flush & ~stall & is_md_op(w_op);
    assign w_bubble   = stall | flush | ~id_valid;

    md_unit #(
        .MD_ITER   (MD_ITER)
    ) u_md_unit (
        .clk       (clk),
        .reset_b   (reset_b),
        .start     (w_md_start),
        .is_div    ((w_op == ALU_DIV) || (w_op == ALU_DIVU)),
        .is_signed ((w_op == ALU_MULT) || (w_op == ALU_DIV)),
        .opa       (opa),
        .opb       (opb),
        .hi        (w_hi),
        .lo        (w_lo),
        .busy      (md_busy)
    );

    always_comb begin
        w_alu = '0;
        case (w_op)
            ALU_ADD:  w_alu = opa + opb;
            ALU_SUB:  w_alu = opa - opb;
            ALU_AND:  w_alu = opa & opb;
            ALU_OR:   w_alu = opa | opb;
            ALU_XOR:  w_alu = opa ^ opb;
            ALU_NOR:  w_alu = ~(opa | opb);
            ALU_SLT:  w_alu = {31'd0, $signed(opa) < $signed(opb)};
            ALU_SLTU: w_alu = {31'd0, opa < opb};
            ALU_SLL:  w_alu = opb << shamt;
            ALU_SRL:  w_alu = opb >> shamt;
            ALU_SRA:  w_alu = $unsigned($signed(opb) >>> shamt);
            ALU_MFHI: w_alu = w_hi;
            ALU_MFLO: w_alu = w_lo;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b || w_bubble) begin
            ex_alu_s      <= '0;
            ex_mem_wdata  <= '0;
            ex_pc_plus4   <= '0;
            ex_lu_data    <= '0;
            ex_write_reg  <= '0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_lu_op      <= 1'b0;
            ex_mem_to_reg <= MEM_TO_REG_ALU;
        end else begin
            ex_alu_s      <= w_alu;
            ex_mem_wdata  <= store_data;
            ex_pc_plus4   <= pc_plus4;
            ex_lu_data    <= lu_data;
            ex_write_reg  <= write_reg;
            ex_mem_read   <= mem_read;
            ex_mem_write  <= mem_write;
            ex_reg_write  <= reg_write;
            ex_lu_op      <= lu_op;
            ex_mem_to_reg <= mem_to_reg;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        id_valid;
    logic [4:0]  alu_op;
    logic [31:0] opa, opb;
    logic [4:0]  shamt;
    logic [31:0] store_data;
    logic [4:0]  write_reg;
    logic        mem_read, mem_write, reg_write, lu_op;
    logic [1:0]  mem_to_reg;
    logic [31:0] pc_plus4, lu_data;
    logic        flush;
    logic        stall;
    logic [31:0] ex_alu_s, ex_mem_wdata, ex_pc_plus4, ex_lu_data;
    logic [4:0]  ex_write_reg;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_lu_op;
    logic [1:0]  ex_mem_to_reg;
    logic        md_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_stage #(.MD_ITER(32)) dut (
        .clk(clk), .reset_b(reset_b), .id_valid(id_valid), .alu_op(alu_op),
        .opa(opa), .opb(opb), .shamt(shamt), .store_data(store_data),
        .write_reg(write_reg), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .lu_op(lu_op), .mem_to_reg(mem_to_reg),
        .pc_plus4(pc_plus4), .lu_data(lu_data), .flush(flush), .stall(stall),
        .ex_alu_s(ex_alu_s), .ex_mem_wdata(ex_mem_wdata),
        .ex_pc_plus4(ex_pc_plus4), .ex_lu_data(ex_lu_data),
        .ex_write_reg(ex_write_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_lu_op(ex_lu_op), .ex_mem_to_reg(ex_mem_to_reg), .md_busy(md_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt;             // cycles the unit still reports busy
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic [31:0] e_alu, e_wdata, e_pc4, e_lu;
    logic [4:0]  e_wreg;
    logic        e_mr, e_mw, e_rw, e_luop;
    logic [1:0]  e_m2r;
    logic        m_st;

    function automatic logic f_md(input logic [4:0] op);
        return op >= 5'd13 && op <= 5'd16;
    endfunction

    function automatic logic f_hilo(input logic [4:0] op);
        return op >= 5'd11 && op <= 5'd16;
    endfunction

    function automatic logic [31:0] f_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd7:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            5'd8:  return b << sh;
            5'd9:  return b >> sh;
            5'd10: return b[31] ? ~((~b) >> sh) : (b >> sh);
            5'd11: return m_hi;
            5'd12: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            5'd13: begin q = sa * sb; hi = q[63:32]; lo = q[31:0]; end
            5'd14: begin uq = ua * ub; hi = uq[63:32]; lo = uq[31:0]; end
            5'd15: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (!reset_b) begin
            m_cnt = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
            e_alu = 0; e_wdata = 0; e_pc4 = 0; e_lu = 0; e_wreg = 0;
            e_mr = 0; e_mw = 0; e_rw = 0; e_luop = 0; e_m2r = 0;
        end else begin
            m_st = id_valid && (m_cnt > 0) && f_hilo(alu_op);
            if (m_st || flush || !id_valid) begin
                e_alu = 0; e_wdata = 0; e_pc4 = 0; e_lu = 0; e_wreg = 0;
                e_mr = 0; e_mw = 0; e_rw = 0; e_luop = 0; e_m2r = 0;
            end else begin
                e_alu = f_alu(alu_op, opa, opb, shamt);
                e_wdata = store_data; e_pc4 = pc_plus4; e_lu = lu_data;
                e_wreg = write_reg; e_mr = mem_read; e_mw = mem_write;
                e_rw = reg_write; e_luop = lu_op; e_m2r = mem_to_reg;
            end
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (id_valid && !flush && f_md(alu_op)) begin
                md_model(alu_op, opa, opb, m_phi, m_plo);
                m_cnt = 33;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_b) begin
            chk("ex_alu_s", ex_alu_s, e_alu);
            chk("ex_mem_wdata", ex_mem_wdata, e_wdata);
            chk("ex_pc_plus4", ex_pc_plus4, e_pc4);
            chk("ex_lu_data", ex_lu_data, e_lu);
            chk("ex_ctrl", {ex_write_reg, ex_mem_read, ex_mem_write, ex_reg_write, ex_lu_op, ex_mem_to_reg},
                {e_wreg, e_mr, e_mw, e_rw, e_luop, e_m2r});
            chk("stall", stall, id_valid && (m_cnt > 0) && f_hilo(alu_op));
            chk("md_busy", md_busy, m_cnt > 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        id_valid = 1'b1; flush = 1'b0; alu_op = op; opa = a; opb = b; shamt = sh;
        store_data = $urandom; write_reg = 5'd3; mem_read = 1'b0; mem_write = 1'b0;
        reg_write = 1'b1; lu_op = 1'b0; mem_to_reg = 2'b00;
        pc_plus4 = $urandom | 32'd4; lu_data = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        id_valid = 1'b0;
        flush = 1'b0;
        while (md_busy && n < 100) begin
            step();
            n++;
        end
        chk("md_wait_bound", {31'd0, n < 100}, 32'd1);
    endtask

    task automatic read_hilo(input string name_lo, input logic [31:0] lo_exp,
                             input string name_hi, input logic [31:0] hi_exp);
        set_op(ALU_MFLO, 0, 0, 0); step(); chk(name_lo, ex_alu_s, lo_exp);
        set_op(ALU_MFHI, 0, 0, 0); step(); chk(name_hi, ex_alu_s, hi_exp);
    endtask

    logic [31:0] specials [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFF9, 32'h7};

    function automatic logic [31:0] rnd_val();
        if ($urandom_range(3) == 0) return specials[$urandom_range(7)];
        return $urandom;
    endfunction

    initial begin
        int n;
        reset_b = 1'b0; id_valid = 0; alu_op = 0; opa = 0; opb = 0; shamt = 0;
        store_data = 0; write_reg = 0; mem_read = 0; mem_write = 0; reg_write = 0;
        lu_op = 0; mem_to_reg = 0; pc_plus4 = 0; lu_data = 0; flush = 0;
        #2;
        chk("reset_alu_s", ex_alu_s, 0);
        chk("reset_reg_write", ex_reg_write, 0);
        chk("reset_md_busy", md_busy, 0);
        repeat (2) step();
        reset_b = 1'b1;

        set_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 0); step();
        chk("add_wrap", ex_alu_s, 32'h8000_0000);
        chk("add_reg_write", ex_reg_write, 1);
        set_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0); step();
        chk("slt", ex_alu_s, 32'd1);
        set_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 0); step();
        chk("sltu", ex_alu_s, 32'd0);
        set_op(ALU_SRA, 32'h0, 32'h8000_0000, 5'd4); step();
        chk("sra", ex_alu_s, 32'hF800_0000);

        // MULT followed immediately by a dependent MFLO.
        set_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 0); step();
        set_op(ALU_MFLO, 0, 0, 0);
        n = 0;
        while (stall && n < 100) begin
            n++;
            step();
        end
        chk("mult_stall_cycles", n, 33);
        step();
        chk("mult_lo", ex_alu_s, 32'hFFFF_FFEB);
        set_op(ALU_MFHI, 0, 0, 0); step();
        chk("mult_hi", ex_alu_s, 32'hFFFF_FFFF);

        set_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0); step(); wait_idle();
        read_hilo("div_lo", 32'hFFFF_FFFD, "div_hi", 32'hFFFF_FFFF);
        set_op(ALU_DIVU, 32'd7, 32'd0, 0); step(); wait_idle();
        read_hilo("divu0_lo", 32'hFFFF_FFFF, "divu0_hi", 32'd7);

        // Asynchronous reset in the middle of a DIVU, with live ADDs in EX/MEM.
        set_op(ALU_DIVU, 32'h1234_5678, 32'd9, 0); step();
        for (int i = 0; i < 9; i++) begin
            set_op(ALU_ADD, 32'(i + 1), 32'h100, 0); step();
        end
        #2 reset_b = 1'b0;
        #1;
        chk("rst_md_busy", md_busy, 0);
        chk("rst_alu_s", ex_alu_s, 0);
        chk("rst_pc_plus4", ex_pc_plus4, 0);
        chk("rst_reg_write", ex_reg_write, 0);
        chk("rst_stall", stall, 0);
        step();
        reset_b = 1'b1;
        read_hilo("rst_lo", 32'd0, "rst_hi", 32'd0);

        set_op(ALU_MULT, 32'd5, 32'd6, 0); flush = 1'b1; step();
        chk("flush_md_busy", md_busy, 0);
        chk("flush_reg_write", ex_reg_write, 0);
        set_op(ALU_MULT, 32'd3, 32'd4, 0); step();
        set_op(ALU_ADD, 32'd10, 32'd20, 0); #1;
        chk("add_busy_nostall", stall, 0);
        step();
        chk("add_busy_result", ex_alu_s, 32'd30);
        wait_idle();
        read_hilo("mult2_lo", 32'd12, "mult2_hi", 32'd0);

        // Randomised traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            op = ($urandom_range(3) == 0) ? 5'($urandom_range(16, 11)) : 5'($urandom_range(16));
            set_op(op, rnd_val(), rnd_val(), 5'($urandom));
            id_valid = ($urandom_range(7) != 0);
            flush = ($urandom_range(15) == 0);
            mem_read = 1'($urandom); mem_write = 1'($urandom);
            reg_write = 1'($urandom); lu_op = 1'($urandom);
            mem_to_reg = 2'($urandom); write_reg = 5'($urandom);
            step();
        end
        wait_idle();
        read_hilo("final_lo", m_lo, "final_hi", m_hi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
